mem_arbiter: RTL and testbench

//  Shares the single byte-wide RAM/IO bus between instruction fetch (word reads) and the
//  MEM stage (byte/half/word loads and stores). Sequences each request into per-byte bus

---
 rtl/mem_arbiter.sv | 228 ++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares the byte-wide RAM/IO bus between instruction fetch (word reads) and the MEM stage.
// Optional MEM_ARB_RR_EN: round-robin on ties; default is fixed MEM-over-IF priority.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter logic [1:0]  IO_HI  = 2'b11
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rdy,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_done,
  output logic [31:0]       o_if_data,
  input  logic              i_mem_req,
  input  logic              i_mem_we,
  input  logic [1:0]        i_mem_size,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [31:0]       i_mem_wdata,
  output logic              o_mem_done,
  output logic [31:0]       o_mem_rdata,
  input  logic [7:0]        i_ram_din,
  output logic [7:0]        o_ram_dout,
  output logic [ADDR_W-1:0] o_ram_a,
  output logic              o_ram_wr,
  input  logic              i_io_buffer_full,
  output logic              o_busy
);

  typedef enum logic [1:0] {StIdle, StRd, StWr} state_e;

  state_e              r_state;
  state_e              w_state_d;
  logic                r_port_mem;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [2:0]          r_n;
  logic [2:0]          r_issue;
  logic [2:0]          r_recv;
  logic                r_vld;
  logic [31:0]         r_rbuf;
  logic                r_if_done;
  logic [31:0]         r_if_data;
  logic                r_mem_done;
  logic [31:0]         r_mem_rdata;

  logic                w_grant;
  logic                w_pick_mem;
  logic [2:0]          w_mem_n;
  logic [2:0]          w_n_m1;
  logic [ADDR_W-1:0]   w_cur_addr;
  logic                w_io_stall;
  logic                w_wr_go;
  logic                w_last_rd;
  logic [31:0]         w_rbuf_d;
  logic [31:0]         w_wshift;

`ifdef MEM_ARB_RR_EN
  // 1 = MEM was granted last; reset value lets IF win the first tie.
  logic r_last_mem;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_mem <= 1'b1;
    end else if (w_grant) begin
      r_last_mem <= w_pick_mem;
    end
  end

  assign w_pick_mem = i_mem_req && (!i_if_req || !r_last_mem);
`else
  assign w_pick_mem = i_mem_req;
`endif

  // No grant while a done pulse is out: the requester is still dropping its request.
  assign w_grant = (r_state == StIdle) && i_rdy && !r_if_done && !r_mem_done &&
                   (i_mem_req || i_if_req);

  always_comb begin
    unique case (i_mem_size)
      2'b00:   w_mem_n = 3'd1;
      2'b01:   w_mem_n = 3'd2;
      default: w_mem_n = 3'd4;
    endcase
  end

  assign w_n_m1     = r_n - 3'd1;
  assign w_cur_addr = r_addr + ADDR_W'(r_issue);
  assign w_io_stall = (w_cur_addr[17:16] == IO_HI) && i_io_buffer_full;
  assign w_wr_go    = i_rdy && !w_io_stall;
  assign w_last_rd  = r_vld && (r_recv == w_n_m1);
  assign w_rbuf_d   = r_rbuf | (32'(i_ram_din) << {r_recv[1:0], 3'b000});
  assign w_wshift   = r_wdata >> {r_issue[1:0], 3'b000};

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_grant) begin
          w_state_d = (w_pick_mem && i_mem_we) ? StWr : StRd;
        end
      end
      StRd: begin
        if (i_rdy && w_last_rd) begin
          w_state_d = StIdle;
        end
      end
      StWr: begin
        if (w_wr_go && (r_issue == w_n_m1)) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Bus outputs
  always_comb begin
    o_ram_a    = '0;
    o_ram_dout = 8'h00;
    o_ram_wr   = 1'b0;
    unique case (r_state)
      StRd: begin
        if (r_issue < r_n) begin
          o_ram_a = w_cur_addr;
        end
      end
      StWr: begin
        o_ram_a    = w_cur_addr;
        o_ram_dout = w_wshift[7:0];
        o_ram_wr   = w_wr_go;
      end
      default: ;
    endcase
  end

  // Datapath: request latch, byte counters, read assembly and completion pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_port_mem  <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= 32'h0;
      r_n         <= 3'd0;
      r_issue     <= 3'd0;
      r_recv      <= 3'd0;
      r_vld       <= 1'b0;
      r_rbuf      <= 32'h0;
      r_if_done   <= 1'b0;
      r_if_data   <= 32'h0;
      r_mem_done  <= 1'b0;
      r_mem_rdata <= 32'h0;
    end else begin
      r_if_done  <= 1'b0;
      r_mem_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_grant) begin
            r_port_mem <= w_pick_mem;
            r_issue    <= 3'd0;
            r_recv     <= 3'd0;
            r_vld      <= 1'b0;
            r_rbuf     <= 32'h0;
            if (w_pick_mem) begin
              r_addr  <= i_mem_addr;
              r_wdata <= i_mem_wdata;
              r_n     <= w_mem_n;
            end else begin
              r_addr <= i_if_addr;
              r_n    <= 3'd4;
            end
          end
        end
        StRd: begin
          if (!i_rdy) begin
            // Drop the in-flight byte and re-issue it after the freeze.
            r_vld   <= 1'b0;
            r_issue <= r_recv;
          end else begin
            if (r_issue < r_n) begin
              r_issue <= r_issue + 3'd1;
              r_vld   <= 1'b1;
            end else begin
              r_vld <= 1'b0;
            end
            if (r_vld) begin
              r_rbuf <= w_rbuf_d;
              r_recv <= r_recv + 3'd1;
              if (w_last_rd) begin
                if (r_port_mem) begin
                  r_mem_done  <= 1'b1;
                  r_mem_rdata <= w_rbuf_d;
                end else begin
                  r_if_done <= 1'b1;
                  r_if_data <= w_rbuf_d;
                end
              end
            end
          end
        end
        StWr: begin
          if (w_wr_go) begin
            r_issue <= r_issue + 3'd1;
            if (r_issue == w_n_m1) begin
              r_mem_done <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_if_done   = r_if_done;
  assign o_if_data   = r_if_data;
  assign o_mem_done  = r_mem_done;
  assign o_mem_rdata = r_mem_rdata;
  assign o_busy      = (r_state != StIdle);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a synchronous byte-RAM model on the bus.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;
  logic        io_full;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_rdy            (rdy),
    .i_if_req         (if_req),
    .i_if_addr        (if_addr),
    .o_if_done        (if_done),
    .o_if_data        (if_data),
    .i_mem_req        (mem_req),
    .i_mem_we         (mem_we),
    .i_mem_size       (mem_size),
    .i_mem_addr       (mem_addr),
    .i_mem_wdata      (mem_wdata),
    .o_mem_done       (mem_done),
    .o_mem_rdata      (mem_rdata),
    .i_ram_din        (ram_din),
    .o_ram_dout       (ram_dout),
    .o_ram_a          (ram_a),
    .o_ram_wr         (ram_wr),
    .i_io_buffer_full (io_full),
    .o_busy           (busy)
  );

  // RAM model: 64 KiB image indexed by ram_a[15:0], read data one cycle after the address.
  logic [7:0]  ram [0:65535];
  logic        pl_en = 1'b0;
  logic [15:0] pl_addr;
  logic [7:0]  pl_data;

  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (ram_wr) ram[ram_a[15:0]] <= ram_dout;
    ram_din <= ram[ram_a[15:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  int          done_cyc;
  logic [31:0] a_log    [0:23];
  logic        wr_log   [0:23];
  logic [7:0]  dout_log [0:23];
  logic        busy_log [0:23];

  // Request must already be driven; k=0 is the cycle after the grant edge.
  task automatic run_txn(input bit is_mem, input int rdy_k, input int io_k);
    done_cyc = -1;
    for (int k = 0; k < 24; k++) begin
      @(posedge clk);
      #1;
      rdy     = (k != rdy_k);
      io_full = (k < io_k);
      @(negedge clk);
      a_log[k]    = ram_a;
      wr_log[k]   = ram_wr;
      dout_log[k] = ram_dout;
      busy_log[k] = busy;
      if (is_mem ? mem_done : if_done) begin
        done_cyc = k;
        break;
      end
    end
    if_req  = 1'b0;
    mem_req = 1'b0;
    rdy     = 1'b1;
    io_full = 1'b0;
  endtask

  task automatic start_mem(input logic we, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] wd);
    @(negedge clk);
    mem_req   = 1'b1;
    mem_we    = we;
    mem_size  = sz;
    mem_addr  = a;
    mem_wdata = wd;
  endtask

  int if_cyc;
  int mem_cyc;

  initial begin
    rst_n = 1'b0; rdy = 1'b1; io_full = 1'b0;
    if_req = 1'b0; if_addr = 32'h0;
    mem_req = 1'b0; mem_we = 1'b0; mem_size = 2'b00; mem_addr = 32'h0; mem_wdata = 32'h0;

    poke(16'h0100, 8'h13); poke(16'h0101, 8'h05); poke(16'h0102, 8'h00); poke(16'h0103, 8'h00);
    poke(16'h0200, 8'h11); poke(16'h0201, 8'h22); poke(16'h0202, 8'h33); poke(16'h0203, 8'h44);
    poke(16'h0300, 8'h78); poke(16'h0301, 8'h56); poke(16'h0302, 8'h34); poke(16'h0303, 8'h12);
    poke(16'h0010, 8'h80); poke(16'h4002, 8'h5A);

    @(negedge clk);
    check("rst_ram_a", ram_a, 32'h0);
    check("rst_ctl", {28'd0, busy, ram_wr, if_done, mem_done}, 32'h0);
    check("rst_data", if_data | mem_rdata | {24'd0, ram_dout}, 32'h0);
    rst_n = 1'b1;

    // Word fetch
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100;
    run_txn(1'b0, -1, 0);
    for (int k = 0; k < 4; k++) check("fetch_addr", a_log[k], 32'h100 + k);
    check("fetch_busy", {31'd0, busy_log[0]}, 32'h1);
    check("fetch_done_cyc", done_cyc, 5);
    check("fetch_data", if_data, 32'h0000_0513);
    @(negedge clk);
    check("fetch_idle_busy", {31'd0, busy}, 32'h0);

    // Word store
    start_mem(1'b1, 2'b10, 32'h2000, 32'hDEAD_BEEF);
    run_txn(1'b1, -1, 0);
    check("st_wr", {28'd0, wr_log[0], wr_log[1], wr_log[2], wr_log[3]}, 32'hF);
    check("st_bytes", {dout_log[3], dout_log[2], dout_log[1], dout_log[0]}, 32'hDEAD_BEEF);
    check("st_addr3", a_log[3], 32'h2003);
    check("st_done_cyc", done_cyc, 4);
    check("st_ram", {ram[16'h2003], ram[16'h2002], ram[16'h2001], ram[16'h2000]}, 32'hDEAD_BEEF);

    // Size 2'b11 loads a word
    start_mem(1'b0, 2'b11, 32'h2000, 32'h0);
    run_txn(1'b1, -1, 0);
    check("ld11_done_cyc", done_cyc, 5);
    check("ld11_data", mem_rdata, 32'hDEAD_BEEF);

    // Simultaneous requests
    start_mem(1'b0, 2'b00, 32'h10, 32'h0);
    if_req = 1'b1; if_addr = 32'h300;
    if_cyc = -1; mem_cyc = -1;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (mem_done && mem_cyc < 0) begin mem_cyc = k; mem_req = 1'b0; end
      if (if_done && if_cyc < 0) begin if_cyc = k; if_req = 1'b0; end
      if (mem_cyc >= 0 && if_cyc >= 0) break;
    end
    if_req = 1'b0; mem_req = 1'b0;
`ifdef MEM_ARB_RR_EN
    check("tie_if_cyc", if_cyc, 5);
    check("tie_mem_cyc", mem_cyc, 9);
`else
    check("tie_mem_cyc", mem_cyc, 2);
    check("tie_if_cyc", if_cyc, 9);
`endif
    check("tie_mem_data", mem_rdata, 32'h0000_0080);
    check("tie_if_data", if_data, 32'h1234_5678);

    // IO store stalled by a full UART buffer
    start_mem(1'b1, 2'b00, 32'h3_0000, 32'h0000_0041);
    io_full = 1'b1;
    run_txn(1'b1, -1, 3);
    check("io_stall_wr", {29'd0, wr_log[0], wr_log[1], wr_log[2]}, 32'h0);
    check("io_hold_addr", a_log[2], 32'h3_0000);
    check("io_write", {23'd0, wr_log[3], dout_log[3]}, 32'h141);
    check("io_done_cyc", done_cyc, 4);
    check("io_ram", {24'd0, ram[16'h0000]}, 32'h41);

    // Freeze in the middle of a word fetch: in-flight byte re-issued
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h200;
    run_txn(1'b0, 3, 0);
    check("rdy_addr3", a_log[3], 32'h203);
    check("rdy_reissue", a_log[4], 32'h202);
    check("rdy_done_cyc", done_cyc, 7);
    check("rdy_data", if_data, 32'h4433_2211);

    // Half load wrapping past the top of the address space
    poke(16'hFFFF, 8'hAB); poke(16'h0000, 8'hCD);
    start_mem(1'b0, 2'b01, 32'hFFFF_FFFF, 32'h0);
    run_txn(1'b1, -1, 0);
    check("wrap_addr1", a_log[1], 32'h0);
    check("wrap_done_cyc", done_cyc, 3);
    check("wrap_data", mem_rdata, 32'h0000_CDAB);

    // Reset during a word store
    start_mem(1'b1, 2'b10, 32'h4000, 32'hCAFE_F00D);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_ctl", {30'd0, ram_wr, busy}, 32'h0);
    mem_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_no_done", {31'd0, mem_done}, 32'h0);
    end
    check("rst_ram", {8'd0, ram[16'h4002], ram[16'h4001], ram[16'h4000]}, 32'h005A_F00D);
    start_mem(1'b0, 2'b01, 32'h4000, 32'h0);
    run_txn(1'b1, -1, 0);
    check("post_rst_done_cyc", done_cyc, 3);
    check("post_rst_data", mem_rdata, 32'h0000_F00D);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
